dual_issue_sched: RTL and testbench

Dual-issue scheduler between instruction fetch and the even/odd execution pipes. Each cycle it inspects the fetched instruction pair and routes it to the pipes. Both instructions go out together when that is legal. Otherwise it splits the pair over successive cycles in program order and stalls fetch until the pair is fully issued. It also keeps issue statistics for performance analysis.

---
 rtl/dual_issue_sched.sv | 203 ++++++++++++++++++++
 tb/tb_dual_issue_sched.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_sched.sv
// Dual-issue scheduler: routes a fetched instruction pair to the even/odd pipes,
// splitting the pair in program order when it cannot go out together.
module dual_issue_sched #(
  parameter int WORD = 32,
  parameter int REGW = 7,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            v1,
  input  logic            v2,
  input  logic [WORD-1:0] instr1,
  input  logic [WORD-1:0] instr2,
  input  logic            pipe1,
  input  logic            pipe2,
  input  logic            wr1,
  input  logic            wr2,
  input  logic [REGW-1:0] rt1,
  input  logic [REGW-1:0] rt2,
  input  logic [REGW-1:0] ra2,
  input  logic [REGW-1:0] rb2,
  input  logic [REGW-1:0] rc2,
  input  logic [2:0]      use2,
  input  logic            haz1,
  input  logic            haz2,
  output logic            fetch_stall,
  output logic            even_valid,
  output logic            odd_valid,
  output logic [WORD-1:0] even_instr,
  output logic [WORD-1:0] odd_instr,
  output logic [CNTW-1:0] dual_cnt,
  output logic [CNTW-1:0] single_cnt,
  output logic [CNTW-1:0] stall_cnt
);

  localparam logic ST_PAIR   = 1'b0;
  localparam logic ST_SECOND = 1'b1;

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic            state_q, state_d;
  logic            even_valid_q, even_valid_d;
  logic            odd_valid_q, odd_valid_d;
  logic [WORD-1:0] even_instr_q, even_instr_d;
  logic [WORD-1:0] odd_instr_q, odd_instr_d;
  logic [CNTW-1:0] dual_cnt_q, dual_cnt_d;
  logic [CNTW-1:0] single_cnt_q, single_cnt_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  logic raw_s, waw_s, conflict_s, dual_ok_s;
  logic issue1_s, issue2_s;
  logic stall_raw_s, fetch_stall_s;
  logic even1_s, even2_s, odd1_s, odd2_s;

  // Intra-pair dependence check: slot 2 may not read or overwrite slot 1's RT.
  always_comb begin
    raw_s = wr1 && ((use2[2] && (rt1 == ra2)) ||
                    (use2[1] && (rt1 == rb2)) ||
                    (use2[0] && (rt1 == rc2)));
    waw_s = wr1 && wr2 && (rt1 == rt2);
    conflict_s = raw_s || waw_s;
    dual_ok_s = v1 && v2 && (pipe1 != pipe2) && !conflict_s && !haz1 && !haz2;
  end

  // State register and all registered outputs/statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_PAIR;
      even_valid_q <= 1'b0;
      odd_valid_q  <= 1'b0;
      even_instr_q <= {WORD{1'b0}};
      odd_instr_q  <= {WORD{1'b0}};
      dual_cnt_q   <= {CNTW{1'b0}};
      single_cnt_q <= {CNTW{1'b0}};
      stall_cnt_q  <= {CNTW{1'b0}};
    end else begin
      state_q      <= state_d;
      even_valid_q <= even_valid_d;
      odd_valid_q  <= odd_valid_d;
      even_instr_q <= even_instr_d;
      odd_instr_q  <= odd_instr_d;
      dual_cnt_q   <= dual_cnt_d;
      single_cnt_q <= single_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Next-state and per-slot issue decision; flush drops the pair without issuing.
  always_comb begin
    state_d  = state_q;
    issue1_s = 1'b0;
    issue2_s = 1'b0;
    if (flush) begin
      state_d = ST_PAIR;
    end else begin
      case (state_q)
        ST_PAIR: begin
          if (dual_ok_s) begin
            issue1_s = 1'b1;
            issue2_s = 1'b1;
            state_d  = ST_PAIR;
          end else if (v1 && !haz1) begin
            issue1_s = 1'b1;
            state_d  = v2 ? ST_SECOND : ST_PAIR;
          end else if (!v1 && v2 && !haz2) begin
            issue2_s = 1'b1;
            state_d  = ST_PAIR;
          end else begin
            state_d = ST_PAIR;
          end
        end
        ST_SECOND: begin
          if (!haz2) begin
            issue2_s = 1'b1;
            state_d  = ST_PAIR;
          end else begin
            state_d = ST_SECOND;
          end
        end
        default: begin
          state_d = ST_PAIR;
        end
      endcase
    end
  end

  // Fetch stall: high unless every valid slot of the presented pair completes now.
  always_comb begin
    stall_raw_s = 1'b0;
    case (state_q)
      ST_PAIR: begin
        if (v1) begin
          stall_raw_s = haz1 || (v2 && !dual_ok_s);
        end else begin
          stall_raw_s = v2 && haz2;
        end
      end
      ST_SECOND: begin
        stall_raw_s = haz2;
      end
      default: begin
        stall_raw_s = 1'b0;
      end
    endcase
    fetch_stall_s = stall_raw_s && !flush && !reset;
  end

  // Route issued slots to their pipes and update the statistics counters.
  always_comb begin
    even1_s = issue1_s && !pipe1;
    even2_s = issue2_s && !pipe2;
    odd1_s  = issue1_s && pipe1;
    odd2_s  = issue2_s && pipe2;

    even_valid_d = even1_s || even2_s;
    odd_valid_d  = odd1_s || odd2_s;

    if (even1_s) begin
      even_instr_d = instr1;
    end else if (even2_s) begin
      even_instr_d = instr2;
    end else begin
      even_instr_d = even_instr_q;
    end

    if (odd1_s) begin
      odd_instr_d = instr1;
    end else if (odd2_s) begin
      odd_instr_d = instr2;
    end else begin
      odd_instr_d = odd_instr_q;
    end

    if (issue1_s && issue2_s) begin
      dual_cnt_d = dual_cnt_q + CNT_ONE;
    end else begin
      dual_cnt_d = dual_cnt_q;
    end

    if (issue1_s ^ issue2_s) begin
      single_cnt_d = single_cnt_q + CNT_ONE;
    end else begin
      single_cnt_d = single_cnt_q;
    end

    if (fetch_stall_s) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  assign fetch_stall = fetch_stall_s;
  assign even_valid  = even_valid_q;
  assign odd_valid   = odd_valid_q;
  assign even_instr  = even_instr_q;
  assign odd_instr   = odd_instr_q;
  assign dual_cnt    = dual_cnt_q;
  assign single_cnt  = single_cnt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_dual_issue_sched.sv
// Bench for dual_issue_sched: expected issues go into a scoreboard queue when the
// pair is driven; a monitor pops and compares them whenever a pipe strobes valid.
module tb_dual_issue_sched;

  logic        clk = 1'b0;
  logic        reset, flush, v1, v2, pipe1, pipe2, wr1, wr2, haz1, haz2;
  logic [31:0] instr1, instr2;
  logic [6:0]  rt1, rt2, ra2, rb2, rc2;
  logic [2:0]  use2;
  logic        fetch_stall, even_valid, odd_valid;
  logic [31:0] even_instr, odd_instr;
  logic [15:0] dual_cnt, single_cnt, stall_cnt;

  typedef struct packed {
    logic        ev;
    logic [31:0] ei;
    logic        ov;
    logic [31:0] oi;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  localparam logic [31:0] IA = 32'hA1A1_0001;
  localparam logic [31:0] IB = 32'hB2B2_0002;
  localparam logic [31:0] IC = 32'hC3C3_0003;
  localparam logic [31:0] ID = 32'hD4D4_0004;

  dual_issue_sched dut (
    .clk(clk), .reset(reset), .flush(flush), .v1(v1), .v2(v2),
    .instr1(instr1), .instr2(instr2), .pipe1(pipe1), .pipe2(pipe2),
    .wr1(wr1), .wr2(wr2), .rt1(rt1), .rt2(rt2), .ra2(ra2), .rb2(rb2), .rc2(rc2),
    .use2(use2), .haz1(haz1), .haz2(haz2), .fetch_stall(fetch_stall),
    .even_valid(even_valid), .odd_valid(odd_valid),
    .even_instr(even_instr), .odd_instr(odd_instr),
    .dual_cnt(dual_cnt), .single_cnt(single_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every issue strobe must match the oldest expected entry.
  always @(posedge clk) begin
    #1;
    if (even_valid || odd_valid) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got ev=%0b ei=%h ov=%0b oi=%h, required no issue",
                 even_valid, even_instr, odd_valid, odd_instr);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (even_valid !== e.ev || odd_valid !== e.ov ||
            (e.ev && even_instr !== e.ei) || (e.ov && odd_instr !== e.oi)) begin
          bad++;
          $display("FAIL issue_data: got ev=%0b ei=%h ov=%0b oi=%h, required ev=%0b ei=%h ov=%0b oi=%h",
                   even_valid, even_instr, odd_valid, odd_instr, e.ev, e.ei, e.ov, e.oi);
        end
      end
    end
  end

  task automatic clear_inputs();
    flush = 1'b0; v1 = 1'b0; v2 = 1'b0; pipe1 = 1'b0; pipe2 = 1'b0;
    wr1 = 1'b0; wr2 = 1'b0; haz1 = 1'b0; haz2 = 1'b0;
    instr1 = 32'h0; instr2 = 32'h0;
    rt1 = 7'd1; rt2 = 7'd2; ra2 = 7'd3; rb2 = 7'd4; rc2 = 7'd6; use2 = 3'b000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
  endtask

  task automatic set_pair(input logic [31:0] a, input logic [31:0] b,
                          input logic pa, input logic pb);
    v1 = 1'b1; v2 = 1'b1; instr1 = a; instr2 = b; pipe1 = pa; pipe2 = pb;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    v1 = 1'b1; haz1 = 1'b1;
    #1;
    total++;
    if (fetch_stall !== 1'b0) begin
      bad++; $display("FAIL reset_stall: got %0b required 0", fetch_stall);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    total++;
    if (even_valid !== 1'b0 || odd_valid !== 1'b0 || even_instr !== 32'h0 ||
        odd_instr !== 32'h0 || dual_cnt !== 16'd0 || single_cnt !== 16'd0 ||
        stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: got ev=%0b ov=%0b ei=%h oi=%h cnt=%0d/%0d/%0d required all 0",
               even_valid, odd_valid, even_instr, odd_instr, dual_cnt, single_cnt, stall_cnt);
    end
    sb_q.delete();
  endtask

  task automatic test_dual();
    do_reset();
    set_pair(IA, IB, 1'b0, 1'b1);
    wr1 = 1'b1; wr2 = 1'b1; use2 = 3'b111;
    sb_q.push_back('{1'b1, IA, 1'b1, IB});
    #1;
    total++;
    if (fetch_stall !== 1'b0) begin
      bad++; $display("FAIL dual_stall: got %0b required 0", fetch_stall);
    end
    @(negedge clk);
    clear_inputs();
    total++;
    if (dual_cnt !== 16'd1 || single_cnt !== 16'd0 || stall_cnt !== 16'd0 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL dual_cnt: got %0d/%0d/%0d pending=%0d required 1/0/0 pending=0",
               dual_cnt, single_cnt, stall_cnt, sb_q.size());
    end
  endtask

  task automatic test_struct_split();
    do_reset();
    set_pair(IA, IB, 1'b1, 1'b1);
    sb_q.push_back('{1'b0, 32'h0, 1'b1, IA});
    #1;
    total++;
    if (fetch_stall !== 1'b1) begin
      bad++; $display("FAIL split_stall1: got %0b required 1", fetch_stall);
    end
    @(negedge clk);
    sb_q.push_back('{1'b0, 32'h0, 1'b1, IB});
    #1;
    total++;
    if (fetch_stall !== 1'b0) begin
      bad++; $display("FAIL split_stall2: got %0b required 0", fetch_stall);
    end
    @(negedge clk);
    clear_inputs();
    total++;
    if (dual_cnt !== 16'd0 || single_cnt !== 16'd2 || stall_cnt !== 16'd1 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL split_cnt: got %0d/%0d/%0d pending=%0d required 0/2/1 pending=0",
               dual_cnt, single_cnt, stall_cnt, sb_q.size());
    end
  endtask

  task automatic test_raw_waw();
    do_reset();
    set_pair(IA, IB, 1'b0, 1'b1);
    wr1 = 1'b1; rt1 = 7'd5; ra2 = 7'd5; use2 = 3'b100;
    sb_q.push_back('{1'b1, IA, 1'b0, 32'h0});
    #1;
    total++;
    if (fetch_stall !== 1'b1) begin
      bad++; $display("FAIL raw_stall: got %0b required 1", fetch_stall);
    end
    @(negedge clk);
    sb_q.push_back('{1'b0, 32'h0, 1'b1, IB});
    @(negedge clk);
    // Same registers but RA not used: no dependence, dual issue.
    set_pair(IC, ID, 1'b0, 1'b1);
    use2 = 3'b000;
    sb_q.push_back('{1'b1, IC, 1'b1, ID});
    #1;
    total++;
    if (fetch_stall !== 1'b0) begin
      bad++; $display("FAIL raw_off_stall: got %0b required 0", fetch_stall);
    end
    @(negedge clk);
    set_pair(IA, IB, 1'b1, 1'b0);
    wr2 = 1'b1; rt1 = 7'd9; rt2 = 7'd9;
    sb_q.push_back('{1'b0, 32'h0, 1'b1, IA});
    @(negedge clk);
    sb_q.push_back('{1'b1, IB, 1'b0, 32'h0});
    @(negedge clk);
    clear_inputs();
    total++;
    if (dual_cnt !== 16'd1 || single_cnt !== 16'd4 || stall_cnt !== 16'd2 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL raw_cnt: got %0d/%0d/%0d pending=%0d required 1/4/2 pending=0",
               dual_cnt, single_cnt, stall_cnt, sb_q.size());
    end
  endtask

  task automatic test_hazard_hold();
    do_reset();
    set_pair(IA, IB, 1'b0, 1'b0);
    haz2 = 1'b1;
    sb_q.push_back('{1'b1, IA, 1'b0, 32'h0});
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (fetch_stall !== 1'b1) begin
        bad++; $display("FAIL hold_stall_%0d: got %0b required 1", i, fetch_stall);
      end
      @(negedge clk);
    end
    haz2 = 1'b0;
    sb_q.push_back('{1'b1, IB, 1'b0, 32'h0});
    #1;
    total++;
    if (fetch_stall !== 1'b0) begin
      bad++; $display("FAIL hold_release: got %0b required 0", fetch_stall);
    end
    @(negedge clk);
    clear_inputs();
    total++;
    if (single_cnt !== 16'd2 || stall_cnt !== 16'd4 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL hold_cnt: got single=%0d stall=%0d pending=%0d required 2/4/0",
               single_cnt, stall_cnt, sb_q.size());
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    v2 = 1'b1; instr2 = IB; pipe2 = 1'b0;
    sb_q.push_back('{1'b1, IB, 1'b0, 32'h0});
    #1;
    total++;
    if (fetch_stall !== 1'b0) begin
      bad++; $display("FAIL misal_stall: got %0b required 0", fetch_stall);
    end
    @(negedge clk);
    haz2 = 1'b1; instr2 = IC;
    #1;
    total++;
    if (fetch_stall !== 1'b1) begin
      bad++; $display("FAIL misal_haz: got %0b required 1", fetch_stall);
    end
    @(negedge clk);
    clear_inputs();
    v1 = 1'b1; haz1 = 1'b1; instr1 = ID;
    #1;
    total++;
    if (fetch_stall !== 1'b1) begin
      bad++; $display("FAIL haz1_stall: got %0b required 1", fetch_stall);
    end
    @(negedge clk);
    clear_inputs();
    total++;
    if (single_cnt !== 16'd1 || stall_cnt !== 16'd2 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL misal_cnt: got single=%0d stall=%0d pending=%0d required 1/2/0",
               single_cnt, stall_cnt, sb_q.size());
    end
  endtask

  task automatic test_flush_reset();
    do_reset();
    set_pair(IA, IB, 1'b1, 1'b1);
    sb_q.push_back('{1'b0, 32'h0, 1'b1, IA});
    @(negedge clk);
    flush = 1'b1;
    #1;
    total++;
    if (fetch_stall !== 1'b0) begin
      bad++; $display("FAIL flush_stall: got %0b required 0", fetch_stall);
    end
    @(negedge clk);
    flush = 1'b0;
    set_pair(IC, ID, 1'b0, 1'b1);
    sb_q.push_back('{1'b1, IC, 1'b1, ID});
    #1;
    total++;
    if (fetch_stall !== 1'b0) begin
      bad++; $display("FAIL flush_next_stall: got %0b required 0", fetch_stall);
    end
    @(negedge clk);
    clear_inputs();
    total++;
    if (dual_cnt !== 16'd1 || single_cnt !== 16'd1 || stall_cnt !== 16'd1 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL flush_cnt: got %0d/%0d/%0d pending=%0d required 1/1/1 pending=0",
               dual_cnt, single_cnt, stall_cnt, sb_q.size());
    end
    set_pair(IA, IB, 1'b0, 1'b0);
    sb_q.push_back('{1'b1, IA, 1'b0, 32'h0});
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (fetch_stall !== 1'b0) begin
      bad++; $display("FAIL midsplit_reset_stall: got %0b required 0", fetch_stall);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    total++;
    if (even_valid !== 1'b0 || odd_valid !== 1'b0 || even_instr !== 32'h0 ||
        odd_instr !== 32'h0 || dual_cnt !== 16'd0 || single_cnt !== 16'd0 ||
        stall_cnt !== 16'd0 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL midsplit_reset: got ev=%0b ov=%0b ei=%h oi=%h cnt=%0d/%0d/%0d pending=%0d required all 0",
               even_valid, odd_valid, even_instr, odd_instr, dual_cnt, single_cnt, stall_cnt, sb_q.size());
    end
    @(negedge clk);
    total++;
    if (even_valid !== 1'b0 || odd_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle: got ev=%0b ov=%0b required 0/0", even_valid, odd_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_dual();
    test_struct_split();
    test_raw_waw();
    test_hazard_hold();
    test_misaligned();
    test_flush_reset();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
